cnt_event_tx: RTL and testbench
===============================

// Module: cnt_event_tx
// PURPOSE
//  Downstream consumer of the loadable counter path. Samples the delayed carry (cy) and the counter
//  value (q) in the clk_sys domain. Each carry rising edge is logged as one q snapshot in a small FIFO.
//  Queued snapshots are sent on a UART-style serial line (tx_out) for an off-chip monitor.
//  Sits beside the top-level datapath on clk_sys; cy/q come from the slower divided-clock counter.
// PARAMETERS
//  DW        4  width of the captured counter value (matches q)
//  DEPTH     4  FIFO entries (power of two, >=2)
//  BAUD_DIV  8  clk_sys cycles per serial bit (>=2)
// PORTS
//  clk_sys  in   1   system clock, all logic on rising edge
//  rst      in   1   reset, asynchronous, active-low
//  q_in     in   DW  counter value, quasi-static between carry events
//  cy_in    in   1   delayed carry, asynchronous to clk_sys, pulse >= 2 clk_sys cycles
//  tx_out   out  1   serial data: idle 1, start 0, DW data bits LSB first, stop 1
//  busy     out  1   high while a frame is on tx_out (START..STOP)
//  ovf      out  1   sticky: an event was dropped because the FIFO was full
//  level    out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, async): tx_out=1, busy=0, ovf=0, level=0. All sync flops, FIFO pointers and FSM cleared.
//  Reset mid-frame aborts the frame. tx_out returns high immediately (async). No partial frame resumes.
//  Sync: cy_in passes through 2 flops (s1,s2), then an edge flop s3. q_in is double-registered in step with cy.
//   ev = s2 & ~s3. Exactly one ev per cy_in rising edge. A high level held indefinitely gives no repeat ev.
//  Push: on ev, the synced q goes into the FIFO if it is not full.
//   If the FIFO is full and no pop occurs that cycle: drop the event, set ovf (stays set until reset).
//   Push and pop in the same cycle, FIFO full: the push is accepted, level unchanged, ovf unchanged.
//   Push and pop in the same cycle, FIFO empty: not possible (pop requires !empty at the clock edge).
//  Pointers wrap modulo DEPTH. level = wr_cnt - rd_cnt on ($clog2(DEPTH)+1)-bit counters.
//  FSM states and transitions:
//   IDLE : tx_out=1, busy=0. If FIFO not empty: pop, load shift reg, reset bit timer, go to START.
//   START: tx_out=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
//   DATA : tx_out=sr[0] for BAUD_DIV cycles, then shift right. bit_idx==DW-1 goes to STOP, else bit_idx+1.
//   STOP : tx_out=1 for BAUD_DIV cycles, then go to IDLE.
//   Illegal state encodings recover to IDLE.
//  tx_out and busy are registered, with no combinational path from inputs.
//  Frame length is exactly (DW+2)*BAUD_DIV cycles. Back-to-back frames: IDLE lasts 1 cycle between them.
//  Latency: cy_in rises before clk_sys edge 1 -> FIFO written at edge 3 -> tx_out=0 after edge 4 (FIFO empty, FSM idle).
//  ev during a frame is only queued. The frame in progress is never disturbed.
// STRUCTURE
//  Shared package cnt_evt_pkg: FSM state localparams (IDLE/START/DATA/STOP, 2-bit) and FRAME_BITS=DW+2.
//  One sub-module: evt_fifo (sync FIFO, params DW/DEPTH; ports push, pop, din, dout, full, empty, level).
//  Top holds the synchronizer, the edge detect, the TX FSM, the baud timer and the shift register.
// TESTING (BAUD_DIV=8, DW=4, DEPTH=4)
//  1 rst low 3 cycles then high -> tx_out=1, busy=0, ovf=0, level=0. No activity with cy_in=0.
//  2 q_in=4'hA, one cy_in pulse -> tx_out low after edge 4. Bits 0,1,0,1 (8 cycles each), then stop 1. busy=1 for 48 cycles.
//  3 Five cy pulses while the first frame is sending (q=1..5): first frame 1, level reaches 4, ovf=0.
//    Frames follow in order 2,3,4,5 with 1 IDLE cycle between frames.
//  4 Six rapid cy pulses before the FIFO drains -> ovf=1 after the 6th. The dropped value is never sent. ovf holds.
//  5 rst low for one cycle mid-DATA -> tx_out=1 at once, level=0. The next cy sends a complete fresh frame.
//  6 cy_in held high 100 cycles -> exactly one frame. A pulse at the full+pop edge -> accepted, level stays 4.

Source files
------------

// File: rtl/cnt_evt_pkg.sv
// Shared definitions for the carry-event serial logger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnt_evt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    // Default counter width and the resulting serial frame length in bit slots
    localparam int CNT_DW     = 4;
    localparam int FRAME_BITS = CNT_DW + 2;

    // Frame duration in clock cycles for a given data width and baud divider
    function automatic int frame_cycles(input int dw, input int baud_div);
        return (dw + 2) * baud_div;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO holding captured counter snapshots, show-ahead read.
// Latency: write visible on dout/level one cycle after push; pop consumes current dout.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module evt_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_cnt;
    logic [AW:0]   r_rd_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    // A full FIFO can still accept a push when the head leaves in the same cycle
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign level = r_wr_cnt - r_rd_cnt;
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign dout  = r_mem[r_rd_cnt[AW-1:0]];

    // Read/write counters carry one extra bit so full and empty are distinguishable
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_do_push) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_do_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written so it needs no reset
    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wr_cnt[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cnt_event_tx.sv
// Logs each carry rising edge as a counter snapshot and ships it out as a UART-style frame.
// Latency: cy_in rise before edge 1 -> queued at edge 3 -> start bit driven after edge 4.
// Backpressure: none upstream; events arriving with the queue full are dropped and flagged in ovf.
module cnt_event_tx
    import cnt_evt_pkg::*;
#(
    parameter int DW       = 4,
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 8
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic [DW-1:0]            q_in,
    input  logic                     cy_in,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

    // Synchronizer, edge detect and snapshot pipeline
    logic          r_s1, r_s2, r_s3;
    logic [DW-1:0] r_q1, r_q2;
    logic          w_ev;

    // Queue interface
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [DW-1:0] w_fifo_dat;
    logic          r_ovf;

    // Transmitter state
    state_t        r_state, w_state_nxt;
    logic [BW-1:0] r_baud,  w_baud_nxt;
    logic [IW-1:0] r_idx,   w_idx_nxt;
    logic [DW-1:0] r_sr,    w_sr_nxt;
    logic          r_tx,    w_tx_nxt;
    logic          r_busy,  w_busy_nxt;
    logic          w_baud_end;

    // Two-flop synchronizer for the carry plus an edge flop; q follows the same two stages
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_s1 <= cy_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_q1 <= q_in;
            r_q2 <= r_q1;
        end
    end

    // One event per synchronized rising edge; a held-high carry produces nothing more
    assign w_ev = r_s2 & ~r_s3;

    evt_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .push    (w_ev),
        .pop     (w_pop),
        .din     (r_q2),
        .dout    (w_fifo_dat),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // Sticky drop flag: set only when an event meets a full queue that is not draining
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_ev && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_baud_end = (r_baud == BAUD_LAST);

    // FSM state register together with the timer, bit index, shifter and registered line outputs
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_sr    <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_sr    <= w_sr_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state logic: each non-idle state holds for BAUD_DIV cycles, data shifts out LSB first
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_idx_nxt   = r_idx;
        w_sr_nxt    = r_sr;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_sr_nxt    = w_fifo_dat;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    w_sr_nxt   = r_sr >> 1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered line changes on the same edge as the state
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: begin
                w_tx_nxt   = 1'b0;
                w_busy_nxt = 1'b1;
            end
            ST_DATA: begin
                w_tx_nxt   = w_sr_nxt[0];
                w_busy_nxt = 1'b1;
            end
            ST_STOP: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_cnt_event_tx.sv
// Directed bench for the carry-event serial logger (DW=4, DEPTH=4, BAUD_DIV=8).
// Latency: frame expectations are built from the 48-cycle frame and 4-edge event latency.
// Backpressure: exercises queue fill, drop with sticky flag, and push-at-pop when full.
module tb_cnt_event_tx;

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       cy_in;
    logic [3:0] q_in;
    logic       tx_out;
    logic       busy;
    logic       ovf;
    logic [2:0] level;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    cnt_event_tx #(
        .DW       (4),
        .DEPTH    (4),
        .BAUD_DIV (8)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .q_in    (q_in),
        .cy_in   (cy_in),
        .tx_out  (tx_out),
        .busy    (busy),
        .ovf     (ovf),
        .level   (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One carry pulse, 3 cycles high then 3 cycles low, with q presented alongside
    task automatic pulse(input logic [3:0] v);
        q_in  = v;
        cy_in = 1'b1;
        repeat (3) @(negedge clk_sys);
        cy_in = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    // Waits for a start bit, then checks every cycle of the 48-cycle frame and the idle cycle after it
    task automatic expect_frame(input logic [3:0] v, input string tag);
        logic [5:0] fr;
        int         k;
        int         nbusy;
        fr = {1'b1, v, 1'b0};
        k  = 0;
        while (tx_out !== 1'b0 && k < 300) begin
            @(negedge clk_sys);
            k++;
        end
        chk($sformatf("%s_start", tag), 32'(tx_out), 32'd0);
        nbusy = 0;
        for (int c = 0; c < 48; c++) begin
            if (busy === 1'b1) nbusy++;
            chk($sformatf("%s_bit_c%0d", tag, c), 32'(tx_out), 32'(fr[c/8]));
            @(negedge clk_sys);
        end
        chk($sformatf("%s_busy_len", tag), 32'(nbusy), 32'd48);
        chk($sformatf("%s_end_tx", tag), 32'(tx_out), 32'd1);
        chk($sformatf("%s_end_busy", tag), 32'(busy), 32'd0);
    endtask

    // Watches the line for n cycles and requires it to stay idle-high throughout
    task automatic idle_watch(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk_sys);
            if (tx_out !== 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst   = 1'b0;
        cy_in = 1'b0;
        q_in  = 4'h0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_tx",    32'(tx_out), 32'd1);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_ovf",   32'(ovf),    32'd0);
        chk("rst_level", 32'(level),  32'd0);
        rst = 1'b1;
        idle_watch(10, "quiet_after_rst");
        chk("quiet_level", 32'(level), 32'd0);

        // Single event latency and frame shape
        q_in  = 4'hA;
        cy_in = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("lat_level_e3", 32'(level),  32'd1);
        chk("lat_tx_e3",    32'(tx_out), 32'd1);
        chk("lat_busy_e3",  32'(busy),   32'd0);
        cy_in = 1'b0;
        @(negedge clk_sys);
        chk("lat_tx_e4",    32'(tx_out), 32'd0);
        chk("lat_busy_e4",  32'(busy),   32'd1);
        chk("lat_level_e4", 32'(level),  32'd0);
        expect_frame(4'hA, "fA");
        idle_watch(10, "idle_after_fA");

        // Five events during a frame: queue reaches 4, frames follow in order with one idle cycle
        fork
            begin
                pulse(4'h1);
                for (int k = 2; k <= 5; k++) pulse(4'(k));
                chk("q_level4", 32'(level), 32'd4);
                chk("q_ovf0",   32'(ovf),   32'd0);
            end
            expect_frame(4'h1, "q1");
        join
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk_sys);
            chk($sformatf("q_gap%0d", k), 32'(tx_out), 32'd0);
            expect_frame(4'(k), $sformatf("q%0d", k));
        end
        idle_watch(20, "idle_after_q");
        chk("q_level_drained", 32'(level), 32'd0);

        // Six rapid events: one in flight, four queued, the sixth dropped
        fork
            begin
                pulse(4'h6);
                for (int k = 7; k <= 10; k++) pulse(4'(k));
                chk("ovf_pre", 32'(ovf), 32'd0);
                pulse(4'hB);
                chk("ovf_set",     32'(ovf),   32'd1);
                chk("ovf_level4",  32'(level), 32'd4);
            end
            expect_frame(4'h6, "o6");
        join
        for (int k = 7; k <= 10; k++) begin
            @(negedge clk_sys);
            chk($sformatf("o_gap%0d", k), 32'(tx_out), 32'd0);
            expect_frame(4'(k), $sformatf("o%0d", k));
        end
        idle_watch(100, "dropped_never_sent");
        chk("ovf_hold", 32'(ovf), 32'd1);

        // Reset in the middle of DATA with one event still queued
        pulse(4'h0);
        pulse(4'h3);
        repeat (4) @(negedge clk_sys);
        chk("mid_busy",  32'(busy),   32'd1);
        chk("mid_tx",    32'(tx_out), 32'd0);
        chk("mid_level", 32'(level),  32'd1);
        rst = 1'b0;
        #1;
        chk("arst_tx",    32'(tx_out), 32'd1);
        chk("arst_busy",  32'(busy),   32'd0);
        chk("arst_level", 32'(level),  32'd0);
        chk("arst_ovf",   32'(ovf),    32'd0);
        @(negedge clk_sys);
        rst = 1'b1;
        idle_watch(20, "no_resume");
        chk("post_rst_level", 32'(level), 32'd0);
        fork
            pulse(4'h5);
            expect_frame(4'h5, "fresh5");
        join

        // Carry held high for 100 cycles yields exactly one frame
        q_in  = 4'h9;
        cy_in = 1'b1;
        fork
            begin
                repeat (100) @(negedge clk_sys);
                cy_in = 1'b0;
            end
            expect_frame(4'h9, "hold9");
        join
        idle_watch(100, "hold_single");
        chk("hold_level", 32'(level), 32'd0);

        // Event landing on the same edge as a pop from a full queue
        fork
            begin
                pulse(4'h1);
                for (int k = 2; k <= 5; k++) pulse(4'(k));
                repeat (20) @(negedge clk_sys);
                chk("fp_pre_level", 32'(level), 32'd4);
                q_in  = 4'hE;
                cy_in = 1'b1;
                repeat (2) @(negedge clk_sys);
                chk("fp_ev_level", 32'(level), 32'd4);
                @(negedge clk_sys);
                cy_in = 1'b0;
                chk("fp_level", 32'(level), 32'd4);
                chk("fp_ovf",   32'(ovf),   32'd0);
            end
            expect_frame(4'h1, "fp1");
        join
        chk("fp_gap2", 32'(tx_out), 32'd0);
        expect_frame(4'h2, "fp2");
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk_sys);
            chk($sformatf("fp_gap%0d", k), 32'(tx_out), 32'd0);
            expect_frame(4'(k), $sformatf("fp%0d", k));
        end
        @(negedge clk_sys);
        chk("fp_gapE", 32'(tx_out), 32'd0);
        expect_frame(4'hE, "fpE");
        idle_watch(20, "final_idle");
        chk("final_level", 32'(level), 32'd0);
        chk("final_ovf",   32'(ovf),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
